// File: rtl/voice_allocator_if.sv
// Event handshake from the keyboard decoder into the voice allocator.
// The sender drives valid/on/note and the allocator answers with ready.
interface voice_allocator_if #(
  parameter int NOTE_W = 8
);
  logic              ev_valid;
  logic              ev_ready;
  logic              ev_on;
  logic [NOTE_W-1:0] ev_note;

  modport master (output ev_valid, ev_on, ev_note, input ev_ready);
  modport slave  (input ev_valid, ev_on, ev_note, output ev_ready);
endinterface

// File: rtl/voice_allocator.sv
// Voice bank sequencer: scans all voices one per cycle for each event, then
// retriggers, allocates, steals the oldest voice, or gates voices off.
module voice_allocator #(
  parameter  int NUM_VOICES = 8,
  parameter  int NOTE_W     = 8,
  parameter  int AGE_W      = 8,
  localparam int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  voice_allocator_if.slave             ev,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic                         alloc_valid,
  output logic [IDX_W-1:0]             alloc_voice,
  output logic                         alloc_stolen
);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t            state, state_n;
  logic              ready_c, accept;
  logic [IDX_W-1:0]  idx;
  logic              on_q;
  logic [NOTE_W-1:0] note_q;
  logic              found_match, found_free, found_old;
  logic [IDX_W-1:0]  match_idx, free_idx, old_idx;
  logic [AGE_W-1:0]  old_age;
  logic [AGE_W-1:0]  age_q [NUM_VOICES];
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_stolen;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_comb begin
    state_n    = state;
    ready_c    = reset_n && (state == IDLE);
    accept     = ready_c && ev.ev_valid;
    sel_idx    = old_idx;
    sel_stolen = 1'b1;
    if (found_match) begin
      sel_idx    = match_idx;
      sel_stolen = 1'b0;
    end else if (found_free) begin
      sel_idx    = free_idx;
      sel_stolen = 1'b0;
    end
    case (state)
      IDLE:    if (accept) state_n = SCAN;
      SCAN:    if (idx == IDX_W'(NUM_VOICES - 1)) state_n = COMMIT;
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign ev.ev_ready = ready_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx          <= '0;
      on_q         <= 1'b0;
      note_q       <= '0;
      found_match  <= 1'b0;
      found_free   <= 1'b0;
      found_old    <= 1'b0;
      match_idx    <= '0;
      free_idx     <= '0;
      old_idx      <= '0;
      old_age      <= '0;
      voice_gate   <= '0;
      voice_note   <= '0;
      alloc_valid  <= 1'b0;
      alloc_voice  <= '0;
      alloc_stolen <= 1'b0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) age_q[i] <= '0;
    end else begin
      alloc_valid <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          on_q        <= ev.ev_on;
          note_q      <= ev.ev_note;
          idx         <= '0;
          found_match <= 1'b0;
          found_free  <= 1'b0;
          found_old   <= 1'b0;
        end
        SCAN: begin
          if (voice_gate[idx] && voice_note[idx*NOTE_W +: NOTE_W] == note_q && !found_match) begin
            found_match <= 1'b1;
            match_idx   <= idx;
          end
          if (!voice_gate[idx] && !found_free) begin
            found_free <= 1'b1;
            free_idx   <= idx;
          end
          // Strict '>' keeps the lowest index on equal ages.
          if (voice_gate[idx] && (!found_old || age_q[idx] > old_age)) begin
            found_old <= 1'b1;
            old_idx   <= idx;
            old_age   <= age_q[idx];
          end
          idx <= idx + 1'b1;
        end
        COMMIT: begin
          for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (on_q) begin
              if (IDX_W'(i) == sel_idx) begin
                voice_gate[i]                  <= 1'b1;
                voice_note[i*NOTE_W +: NOTE_W] <= note_q;
                age_q[i]                       <= '0;
              end else if (voice_gate[i] && age_q[i] != '1) begin
                age_q[i] <= age_q[i] + 1'b1;
              end
            end else if (voice_gate[i] && voice_note[i*NOTE_W +: NOTE_W] == note_q) begin
              voice_gate[i] <= 1'b0;
            end
          end
          if (on_q) begin
            alloc_valid  <= 1'b1;
            alloc_voice  <= sel_idx;
            alloc_stolen <= sel_stolen;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed-vector bench for voice_allocator (8 voices, 8-bit notes/ages).
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  voice_gate;
  logic [63:0] voice_note;
  logic        alloc_valid;
  logic [2:0]  alloc_voice;
  logic        alloc_stolen;
  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          hs_cnt  = 0;

  voice_allocator_if #(.NOTE_W(8)) ev_if ();

  voice_allocator #(.NUM_VOICES(8), .NOTE_W(8), .AGE_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ev          (ev_if.slave),
    .voice_gate  (voice_gate),
    .voice_note  (voice_note),
    .alloc_valid (alloc_valid),
    .alloc_voice (alloc_voice),
    .alloc_stolen(alloc_stolen)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (ev_if.ev_valid && ev_if.ev_ready) hs_cnt++;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 1ms");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Waits for ready, hands one event over, then waits until ready again.
  // Returns at the negedge of the first ready cycle.
  task automatic send(input logic on, input logic [7:0] note,
                      output int busy, output logic pulsed);
    int n;
    @(negedge clk);
    n = 0;
    while (!ev_if.ev_ready && n < 100) begin @(negedge clk); n++; end
    ev_if.ev_valid = 1'b1;
    ev_if.ev_on    = on;
    ev_if.ev_note  = note;
    @(negedge clk);
    ev_if.ev_valid = 1'b0;
    busy = 0;
    while (!ev_if.ev_ready && busy < 100) begin @(negedge clk); busy++; end
    pulsed = alloc_valid;
  endtask

  initial begin
    int   busy;
    logic p;
    logic saw;
    int   n;

    ev_if.ev_valid = 1'b0;
    ev_if.ev_on    = 1'b0;
    ev_if.ev_note  = '0;

    // Reset state
    #2;
    check("rst_ready", ev_if.ev_ready, 0);
    check("rst_gate", voice_gate, 0);
    check("rst_note", voice_note, 0);
    check("rst_alloc", {alloc_valid, alloc_voice, alloc_stolen}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 check("ready_after_rst", ev_if.ev_ready, 1);

    // 1: first note-on lands in voice 0
    send(1'b1, 8'd40, busy, p);
    check("t1_busy", busy, 9);
    check("t1_pulse", p, 1);
    check("t1_voice", alloc_voice, 0);
    check("t1_stolen", alloc_stolen, 0);
    check("t1_gate", voice_gate, 8'h01);
    check("t1_note0", voice_note[7:0], 40);
    @(negedge clk);
    check("t1_pulse_width", alloc_valid, 0);

    // 2: fill voices 1,2 then release 41
    send(1'b1, 8'd41, busy, p);
    check("t2_voice41", alloc_voice, 1);
    send(1'b1, 8'd42, busy, p);
    check("t2_voice42", alloc_voice, 2);
    check("t2_gate_on", voice_gate, 8'h07);
    send(1'b0, 8'd41, busy, p);
    check("t2_off_busy", busy, 9);
    check("t2_off_pulse", p, 0);
    check("t2_gate_off", voice_gate, 8'h05);
    check("t2_note1_kept", voice_note[15:8], 41);
    check("t2_voice_hold", alloc_voice, 2);

    // 3: retrigger of an already sounding note
    do_reset();
    send(1'b1, 8'd10, busy, p);
    send(1'b1, 8'd11, busy, p);
    send(1'b1, 8'd12, busy, p);
    send(1'b1, 8'd50, busy, p);
    check("t3_setup_voice", alloc_voice, 3);
    send(1'b1, 8'd50, busy, p);
    check("t3_pulse", p, 1);
    check("t3_voice", alloc_voice, 3);
    check("t3_stolen", alloc_stolen, 0);
    check("t3_gate", voice_gate, 8'h0F);
    check("t3_age3", dut.age_q[3], 0);
    check("t3_age0", dut.age_q[0], 4);

    // 4: fill all voices then steal the oldest twice
    do_reset();
    for (int i = 0; i < 8; i++) send(1'b1, 8'(60 + i), busy, p);
    check("t4_full", voice_gate, 8'hFF);
    check("t4_last_voice", alloc_voice, 7);
    send(1'b1, 8'd70, busy, p);
    check("t4_steal0_voice", alloc_voice, 0);
    check("t4_steal0_stolen", alloc_stolen, 1);
    check("t4_steal0_note", voice_note[7:0], 70);
    send(1'b1, 8'd71, busy, p);
    check("t4_steal1_voice", alloc_voice, 1);
    check("t4_steal1_stolen", alloc_stolen, 1);

    // 5: unmatched note-off changes nothing
    send(1'b0, 8'd99, busy, p);
    check("t5_off_pulse", p, 0);
    check("t5_gate", voice_gate, 8'hFF);
    check("t5_notes", voice_note, 64'h4342_4140_3F3E_4746);
    check("t5_alloc_hold", {alloc_voice, alloc_stolen}, {3'd1, 1'b1});

    // 5b: valid held through a busy window is taken once, on the first idle cycle
    hs_cnt = 0;
    @(negedge clk);
    ev_if.ev_valid = 1'b1;
    ev_if.ev_on    = 1'b1;
    ev_if.ev_note  = 8'd80;
    @(negedge clk);
    ev_if.ev_note  = 8'd81;
    n = 0;
    while (!ev_if.ev_ready && n < 100) begin @(negedge clk); n++; end
    check("t5_hold_busy", n, 9);
    check("t5_first_pulse", alloc_valid, 1);
    check("t5_first_voice", alloc_voice, 2);
    @(negedge clk);
    ev_if.ev_valid = 1'b0;
    n = 0;
    while (!ev_if.ev_ready && n < 100) begin @(negedge clk); n++; end
    check("t5_second_voice", alloc_voice, 3);
    check("t5_second_stolen", alloc_stolen, 1);
    check("t5_handshakes", hs_cnt, 2);
    check("t5_notes_after", voice_note, 64'h4342_4140_5150_4746);

    // 6: reset while scanning a note-on
    do_reset();
    send(1'b1, 8'd90, busy, p);
    send(1'b1, 8'd95, busy, p);
    check("t6_setup_voice", alloc_voice, 1);
    @(negedge clk);
    ev_if.ev_valid = 1'b1;
    ev_if.ev_on    = 1'b1;
    ev_if.ev_note  = 8'd91;
    @(negedge clk);
    ev_if.ev_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("t6_gate", voice_gate, 0);
    check("t6_note", voice_note, 0);
    check("t6_alloc", {alloc_valid, alloc_voice, alloc_stolen}, 0);
    check("t6_ready_in_rst", ev_if.ev_ready, 0);
    saw = 1'b0;
    repeat (3) begin @(negedge clk); saw |= alloc_valid; end
    reset_n = 1'b1;
    repeat (3) begin @(negedge clk); saw |= alloc_valid; end
    check("t6_no_pulse", saw, 0);
    check("t6_ready_after", ev_if.ev_ready, 1);
    send(1'b1, 8'd92, busy, p);
    check("t6_next_pulse", p, 1);
    check("t6_next_voice", alloc_voice, 0);
    check("t6_next_gate", voice_gate, 8'h01);
    check("t6_next_note", voice_note[7:0], 92);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
